// File: rtl/window_3x3_gen_if.sv
// ---------------------------------------------------------------------------
// window_3x3_gen_if
//   Bundle between a raster pixel source, the 3x3 window generator and the
//   convolution stage that consumes its windows.
//
//   Handshake: valid-only, with no ready signal. in_valid=1 means in_data is
//   taken on that rising edge, with no way to refuse it. win_valid=1 means
//   win/out_row/out_col/frame_done describe one window on that cycle, and the
//   consumer must take it.
//
//   Signals:
//     in_valid    pixel present this cycle
//     in_data     pixel, raster order
//     win_valid   window outputs valid this cycle
//     win         9 pixels, slice [(3*i+j)*W +: W] = (row r-2+i, col c-2+j)
//     out_row     top-left row of the window
//     out_col     top-left column of the window
//     frame_done  pulse with the last window of a frame
//
//   Modports: master = pixel source / window consumer, slave = generator.
// ---------------------------------------------------------------------------
interface window_3x3_gen_if #(
  parameter int W     = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            win_valid;
  logic [9*W-1:0]  win;
  logic [RW-1:0]   out_row;
  logic [CW-1:0]   out_col;
  logic            frame_done;

  modport master (
    output in_valid, in_data,
    input  win_valid, win, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output win_valid, win, out_row, out_col, frame_done
  );
endinterface

// File: rtl/window_3x3_gen.sv
// ---------------------------------------------------------------------------
// window_3x3_gen
//   Streaming 3x3 sliding-window generator. It accepts one raster-order pixel
//   per in_valid cycle and keeps the two previous rows in line buffers. For
//   every pixel at (r,c) with r>=2 and c>=2 it emits, one clock later, the 3x3
//   neighbourhood with that pixel at the bottom-right, together with its
//   top-left coordinate. It also emits a frame_done pulse with the last
//   window of the frame.
//
//   Ports:
//     clk      rising-edge clock
//     reset_b  asynchronous, active-low reset
//     bus      window_3x3_gen_if.slave (pixel input, window output)
// ---------------------------------------------------------------------------
module window_3x3_gen #(
  parameter int W     = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                 clk,
  input  logic                 reset_b,
  window_3x3_gen_if.slave      bus
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  // Position of the pixel being accepted this cycle.
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;

  // Line buffers addressed by column. Each entry is rewritten once per row,
  // so reading an entry before it is rewritten gives the same column one row
  // earlier (LB0) or two rows earlier (LB1, fed from LB0).
  logic [W-1:0]   r_lb0 [IMG_W];
  logic [W-1:0]   r_lb1 [IMG_W];

  // Working window. It shifts on every accepted pixel, including those that
  // do not produce a window.
  logic [W-1:0]   r_win [9];
  logic [W-1:0]   w_win_nxt [9];
  logic [9*W-1:0] w_win_flat;

  // Output registers. They change only when a window is emitted, so they
  // hold between windows.
  logic           r_win_valid;
  logic [9*W-1:0] r_win_out;
  logic [RW-1:0]  r_out_row;
  logic [CW-1:0]  r_out_col;
  logic           r_frame_done;

  logic           w_accept;
  logic           w_last_col;
  logic           w_last_row;
  logic           w_emit;
  logic           w_frame_end;
  logic [W-1:0]   w_top;
  logic [W-1:0]   w_mid;

  assign w_accept    = bus.in_valid;
  assign w_last_col  = (r_col == CW'(IMG_W - 1));
  assign w_last_row  = (r_row == RW'(IMG_H - 1));
  assign w_emit      = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_frame_end = w_accept && w_last_row && w_last_col;
  assign w_top       = r_lb1[r_col];
  assign w_mid       = r_lb0[r_col];

  // New column enters at j=2; the older columns move one place left.
  always_comb begin
    w_win_nxt[0] = r_win[1];
    w_win_nxt[1] = r_win[2];
    w_win_nxt[2] = w_top;
    w_win_nxt[3] = r_win[4];
    w_win_nxt[4] = r_win[5];
    w_win_nxt[5] = w_mid;
    w_win_nxt[6] = r_win[7];
    w_win_nxt[7] = r_win[8];
    w_win_nxt[8] = bus.in_data;
  end

  always_comb begin
    w_win_flat = '0;
    for (int k = 0; k < 9; k++) begin
      w_win_flat[k*W +: W] = w_win_nxt[k];
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < IMG_W; k++) begin
        r_lb0[k] <= '0;
        r_lb1[k] <= '0;
      end
    end else if (w_accept) begin
      r_lb0[r_col] <= bus.in_data;
      r_lb1[r_col] <= w_mid;
    end
  end

  // Working window.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= w_win_nxt[k];
      end
    end
  end

  // Output stage, one clock after acceptance.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_out    <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
    end else begin
      r_win_valid  <= w_emit;
      r_frame_done <= w_frame_end;
      if (w_emit) begin
        r_win_out <= w_win_flat;
        r_out_row <= r_row - RW'(2);
        r_out_col <= r_col - CW'(2);
      end
    end
  end

  assign bus.win_valid  = r_win_valid;
  assign bus.win        = r_win_out;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_window_3x3_gen.sv
// ---------------------------------------------------------------------------
// tb_window_3x3_gen
//   Bench for window_3x3_gen. It uses a 4x4 instance for the directed
//   scenarios and a default 28x28 instance for random data. Expected windows
//   are built directly from stored image arrays by pixel coordinate.
// ---------------------------------------------------------------------------
module tb_window_3x3_gen;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst4_b;
  logic rst28_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  window_3x3_gen_if #(.W(W), .IMG_W(4),  .IMG_H(4))  bus4  ();
  window_3x3_gen_if #(.W(W), .IMG_W(28), .IMG_H(28)) bus28 ();

  window_3x3_gen #(.W(W), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk     (clk),
    .reset_b (rst4_b),
    .bus     (bus4)
  );

  window_3x3_gen #(.W(W), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk     (clk),
    .reset_b (rst28_b),
    .bus     (bus28)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [W-1:0]   img4  [2][16];
  logic [W-1:0]   img28 [784];
  logic [9*W-1:0] exp_q [$];
  logic [9:0]     exp_pos_q [$];   // {row[4:0], col[4:0]}
  logic           exp_fd_q [$];

  function automatic logic [9*W-1:0] model_win4(input int f, input int r, input int c);
    logic [9*W-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*W +: W] = img4[f][(r-2+i)*4 + (c-2+j)];
    return w;
  endfunction

  function automatic logic [9*W-1:0] model_win28(input int r, input int c);
    logic [9*W-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*W +: W] = img28[(r-2+i)*28 + (c-2+j)];
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive4(input logic v, input logic [W-1:0] d);
    bus4.in_valid = v;
    bus4.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive28(input logic v, input logic [W-1:0] d);
    bus28.in_valid = v;
    bus28.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    bus4.in_valid = 1'b0;
    rst4_b = 1'b0;
    #3;
    rst4_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if (bus4.win_valid !== 1'b0 || bus4.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4_ctrl: got valid=%b fd=%b want 0 0", bus4.win_valid, bus4.frame_done);
    end
    n_checks++;
    if (bus4.win !== '0 || bus4.out_row !== '0 || bus4.out_col !== '0) begin
      n_fail++;
      $display("FAIL reset4_data: got win=%h row=%0d col=%0d want 0", bus4.win, bus4.out_row, bus4.out_col);
    end
    n_checks++;
    if (bus28.win_valid !== 1'b0 || bus28.frame_done !== 1'b0 || bus28.win !== '0 ||
        bus28.out_row !== '0 || bus28.out_col !== '0) begin
      n_fail++;
      $display("FAIL reset28: got valid=%b fd=%b win=%h want all 0", bus28.win_valid, bus28.frame_done, bus28.win);
    end
  endtask

  task automatic test_continuous();
    int r, c, nwin;
    logic e;
    nwin = 0;
    reset4();
    for (int k = 0; k < 16; k++) img4[0][k] = W'(k);
    for (int k = 0; k < 16; k++) begin
      r = k / 4; c = k % 4;
      e = (r >= 2 && c >= 2);
      drive4(1'b1, img4[0][k]);
      n_checks++;
      if (bus4.win_valid !== e) begin
        n_fail++;
        $display("FAIL cont_valid pix %0d: got %b want %b", k, bus4.win_valid, e);
      end
      if (e) begin
        nwin++;
        n_checks++;
        if (bus4.win !== model_win4(0, r, c)) begin
          n_fail++;
          $display("FAIL cont_win pix %0d: got %h want %h", k, bus4.win, model_win4(0, r, c));
        end
        n_checks++;
        if (bus4.out_row !== 2'(r-2) || bus4.out_col !== 2'(c-2) || bus4.frame_done !== (k == 15)) begin
          n_fail++;
          $display("FAIL cont_pos pix %0d: got (%0d,%0d) fd=%b want (%0d,%0d) fd=%b",
                   k, bus4.out_row, bus4.out_col, bus4.frame_done, r-2, c-2, (k == 15));
        end
      end
    end
    drive4(1'b0, '0);
    n_checks++;
    if (bus4.win_valid !== 1'b0 || nwin != 4) begin
      n_fail++;
      $display("FAIL cont_count: got %0d windows, trailing valid=%b want 4, 0", nwin, bus4.win_valid);
    end
  endtask

  task automatic test_gaps();
    int k, r, c, nwin;
    logic v, e;
    logic [W-1:0]   d;
    logic [9*W-1:0] lw;
    logic [1:0]     lr, lc;
    k = 0; nwin = 0; lw = '0; lr = '0; lc = '0;
    reset4();
    for (int cy = 0; cy < 32; cy++) begin
      v = (cy % 2 == 0);
      r = k / 4; c = k % 4;
      e = v && r >= 2 && c >= 2;
      d = 16'hDEAD;
      if (v) d = img4[0][k];
      drive4(v, d);
      n_checks++;
      if (bus4.win_valid !== e || bus4.frame_done !== (e && k == 15)) begin
        n_fail++;
        $display("FAIL gap_valid cycle %0d: got v=%b fd=%b want v=%b fd=%b",
                 cy, bus4.win_valid, bus4.frame_done, e, (e && k == 15));
      end
      if (e) begin
        nwin++;
        lw = model_win4(0, r, c); lr = 2'(r-2); lc = 2'(c-2);
      end
      n_checks++;
      if (bus4.win !== lw || bus4.out_row !== lr || bus4.out_col !== lc) begin
        n_fail++;
        $display("FAIL gap_data cycle %0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                 cy, bus4.win, bus4.out_row, bus4.out_col, lw, lr, lc);
      end
      if (v) k++;
    end
    n_checks++;
    if (nwin != 4) begin
      n_fail++;
      $display("FAIL gap_count: got %0d want 4", nwin);
    end
  endtask

  task automatic test_back_to_back();
    int f, p, r, c, nwin;
    logic e;
    nwin = 0;
    reset4();
    for (int k = 0; k < 16; k++) img4[1][k] = W'(100 + k);
    for (int k = 0; k < 32; k++) begin
      f = k / 16; p = k % 16; r = p / 4; c = p % 4;
      e = (r >= 2 && c >= 2);
      drive4(1'b1, img4[f][p]);
      n_checks++;
      if (bus4.win_valid !== e || bus4.frame_done !== (p == 15)) begin
        n_fail++;
        $display("FAIL b2b_valid pix %0d: got v=%b fd=%b want v=%b fd=%b",
                 k, bus4.win_valid, bus4.frame_done, e, (p == 15));
      end
      if (e) begin
        nwin++;
        n_checks++;
        if (bus4.win !== model_win4(f, r, c) || bus4.out_row !== 2'(r-2) || bus4.out_col !== 2'(c-2)) begin
          n_fail++;
          $display("FAIL b2b_win pix %0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                   k, bus4.win, bus4.out_row, bus4.out_col, model_win4(f, r, c), r-2, c-2);
        end
      end
    end
    n_checks++;
    if (nwin != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 8", nwin);
    end
  endtask

  // Runs straight after test_back_to_back without its own reset, so the
  // outputs still hold the last window of that test when reset hits.
  task automatic test_reset_mid_frame();
    int r, c, nacc, first_at, nwin;
    logic e;
    nacc = 0; first_at = -1; nwin = 0;
    for (int k = 0; k < 10; k++) drive4(1'b1, img4[0][k]);
    bus4.in_valid = 1'b0;
    rst4_b = 1'b0;
    #2;
    n_checks++;
    if (bus4.win_valid !== 1'b0 || bus4.win !== '0 || bus4.out_row !== '0 ||
        bus4.out_col !== '0 || bus4.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_zero: got v=%b win=%h (%0d,%0d) fd=%b want all 0",
               bus4.win_valid, bus4.win, bus4.out_row, bus4.out_col, bus4.frame_done);
    end
    #2;
    rst4_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      r = k / 4; c = k % 4;
      e = (r >= 2 && c >= 2);
      drive4(1'b1, img4[0][k]);
      nacc++;
      if (bus4.win_valid === 1'b1 && first_at < 0) first_at = nacc;
      if (e) begin
        nwin++;
        n_checks++;
        if (bus4.win_valid !== 1'b1 || bus4.win !== model_win4(0, r, c) ||
            bus4.out_row !== 2'(r-2) || bus4.out_col !== 2'(c-2)) begin
          n_fail++;
          $display("FAIL midrst_win pix %0d: got v=%b %h (%0d,%0d) want 1 %h (%0d,%0d)",
                   k, bus4.win_valid, bus4.win, bus4.out_row, bus4.out_col, model_win4(0, r, c), r-2, c-2);
        end
      end
    end
    n_checks++;
    if (first_at != 11 || nwin != 4) begin
      n_fail++;
      $display("FAIL midrst_first: got first window after %0d pixels want 11", first_at);
    end
  endtask

  task automatic test_row_boundary();
    int k, r, c, cy;
    logic v, e;
    logic [9*W-1:0] lw;
    logic [1:0]     lr, lc;
    k = 0; cy = 0; lw = '0; lr = '0; lc = '0;
    reset4();
    for (int i = 0; i < 16; i++) img4[0][i] = W'($urandom);
    while (k < 16 && cy < 200) begin
      v = ($urandom_range(0, 2) != 0);
      r = k / 4; c = k % 4;
      e = v && r >= 2 && c >= 2;
      drive4(v, v ? img4[0][k] : W'($urandom));
      n_checks++;
      if (bus4.win_valid !== e) begin
        n_fail++;
        $display("FAIL rowb_valid pix %0d acc=%b: got %b want %b", k, v, bus4.win_valid, e);
      end
      if (e) begin
        lw = model_win4(0, r, c); lr = 2'(r-2); lc = 2'(c-2);
      end
      n_checks++;
      if (bus4.win !== lw || bus4.out_row !== lr || bus4.out_col !== lc) begin
        n_fail++;
        $display("FAIL rowb_data pix %0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                 k, bus4.win, bus4.out_row, bus4.out_col, lw, lr, lc);
      end
      if (v) k++;
      cy++;
    end
    bus4.in_valid = 1'b0;
    n_checks++;
    if (k != 16) begin
      n_fail++;
      $display("FAIL rowb_budget: got %0d pixels accepted want 16", k);
    end
  endtask

  task automatic test_random_28();
    int k, r, c, cy, nwin, nfd, fd_row, fd_col;
    logic v;
    logic [W-1:0]   d;
    logic [9*W-1:0] ew;
    logic [9:0]     ep;
    logic           ef;
    k = 0; cy = 0; nwin = 0; nfd = 0; fd_row = -1; fd_col = -1;
    while (k < 784 && cy < 3000) begin
      v = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      if (v) begin
        r = k / 28; c = k % 28;
        if ($urandom_range(0, 7) == 0 || r == 14) d = 16'hFFFF;
        img28[k] = d;
        if (r >= 2 && c >= 2) begin
          exp_q.push_back(model_win28(r, c));
          exp_pos_q.push_back({5'(r-2), 5'(c-2)});
          exp_fd_q.push_back(k == 783);
        end
        k++;
      end
      drive28(v, d);
      if (bus28.frame_done === 1'b1) begin
        nfd++; fd_row = int'(bus28.out_row); fd_col = int'(bus28.out_col);
      end
      if (bus28.win_valid === 1'b1) begin
        nwin++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL r28_extra: got unexpected window at cycle %0d want none", cy);
        end else begin
          ew = exp_q.pop_front(); ep = exp_pos_q.pop_front(); ef = exp_fd_q.pop_front();
          if (bus28.win !== ew || {bus28.out_row, bus28.out_col} !== ep || bus28.frame_done !== ef) begin
            n_fail++;
            $display("FAIL r28_win cycle %0d: got %h (%0d,%0d) fd=%b want %h (%0d,%0d) fd=%b", cy,
                     bus28.win, bus28.out_row, bus28.out_col, bus28.frame_done, ew, ep[9:5], ep[4:0], ef);
          end
        end
      end
      cy++;
    end
    drive28(1'b0, '0);
    n_checks++;
    if (k != 784 || nwin != 676 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL r28_count: got %0d windows, %0d left, %0d pixels want 676, 0, 784", nwin, exp_q.size(), k);
    end
    n_checks++;
    if (nfd != 1 || fd_row != 25 || fd_col != 25) begin
      n_fail++;
      $display("FAIL r28_frame_done: got %0d pulses at (%0d,%0d) want 1 at (25,25)", nfd, fd_row, fd_col);
    end
    rst28_b = 1'b0;
    #2;
    n_checks++;
    if (bus28.win !== '0 || bus28.out_row !== '0 || bus28.out_col !== '0 || bus28.win_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL r28_reset: got win=%h (%0d,%0d) want 0", bus28.win, bus28.out_row, bus28.out_col);
    end
    #2;
    rst28_b = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst4_b = 1'b0;
    rst28_b = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_data = '0;
    bus28.in_valid = 1'b0;
    bus28.in_data = '0;
    #12;
    test_reset();
    rst4_b = 1'b1;
    rst28_b = 1'b1;
    @(posedge clk);
    #1;
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_row_boundary();
    test_random_28();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 sliding-window generator. It sits directly upstream of the convolution stage and its alignment delay lines. It accepts one raster-order pixel per valid cycle and buffers the previous two image rows internally. For every input pixel that completes a full 3x3 neighbourhood, it emits that neighbourhood as a flat bus. Window coordinates and an end-of-frame pulse travel alongside, so downstream delay lines can keep control aligned with the convolution pipeline.

## Interface
Parameters:
- W, 16, pixel width in bits
- IMG_W, 28, image width in pixels (≥3)
- IMG_H, 28, image height in pixels (≥3)

Ports:
- clk  input  1  clock, rising edge
- reset_b  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data holds a pixel this cycle
- in_data  input  W  pixel, raster order (row-major, top-left first)
- win_valid  output  1  win/out_row/out_col valid this cycle
- win  output  9*W  window; slice [(3*i+j)*W +: W] = pixel (row r-2+i, col c-2+j)
- out_row  output  clog2(IMG_H)  top-left row of window (r-2)
- out_col  output  clog2(IMG_W)  top-left col of window (c-2)
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Internal counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position (r,c) of the pixel accepted this cycle.
- A pixel is accepted on any cycle with in_valid=1. There is no backpressure; downstream always accepts.
- Accepted pixel handling:
  - col increments.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0 and the next accepted pixel starts a new frame.
- Line buffers:
  - Two IMG_W-deep line buffers, LB0 and LB1. LB0 delays by one row; LB1 is fed from LB0's output and delays by a further row.
  - Both advance only on accepted pixels.
  - Column presented on acceptance: top = LB1 out, mid = LB0 out, bottom = in_data. These are pixels (r-2,c), (r-1,c) and (r,c).
- 3x3 window register:
  - On acceptance, shifts one column left; the new column enters at j=2.
  - Slice 8 is always the newest pixel; slice 0 is the oldest.
- Window emission:
  - A window is emitted for an accepted pixel with r≥2 and c≥2 (valid convolution, no padding).
  - Per frame: (IMG_W-2)*(IMG_H-2) windows.
  - No window is emitted for c=0 or c=1 of any row, even though those windows would contain stale columns from the previous row.
- in_valid=0: counters, line buffers and window hold; win_valid=0 and frame_done=0.
- Data is not modified. No arithmetic is performed on pixels; values pass through bit-exact.

## Timing
- Reset values:
  - All outputs 0: win_valid=0, win=0, out_row=0, out_col=0, frame_done=0.
  - Counters 0.
  - Line buffers and window registers 0.
- Reset is asynchronous. Asserting it mid-frame discards the partial frame. After release, the first accepted pixel is (0,0).
- Latency is one clock. For an accepted pixel at (r,c) with r≥2 and c≥2, in the following cycle:
  - win_valid=1;
  - win holds rows r-2..r, cols c-2..c;
  - out_row=r-2, out_col=c-2.
- win_valid is high for exactly one cycle per qualifying pixel.
- Back-to-back in_valid produces back-to-back win_valid. Gaps in in_valid produce matching gaps in win_valid.
- frame_done=1 in the same cycle as the win_valid for pixel (IMG_H-1, IMG_W-1), i.e. out_row=IMG_H-3, out_col=IMG_W-3.
- Frames back to back: the first pixel of frame N+1 may arrive the cycle after the last pixel of frame N.
  - No bubble is required.
  - Line-buffer residue from frame N is never emitted, because row<2 blocks emission.
- out_row, out_col and win hold their last values while win_valid=0.

## Test plan
- IMG_W=IMG_H=4, continuous in_valid, pixel value = 4*r+c:
  - first win_valid one cycle after pixel 10, with win slices 0..8 = 0,1,2,4,5,6,8,9,10 and (out_row,out_col)=(0,0);
  - exactly 4 windows in total;
  - last window = 5,6,7,9,10,11,13,14,15 with frame_done=1 at (1,1).
- Same image with in_valid toggling 1,0,1,0… → identical window sequence and values; win_valid only on cycles following accepted pixels; nothing emitted during gaps.
- Two consecutive 4x4 frames, second frame value = 100+4*r+c, no gap → second frame's first window = 100,101,102,104,105,106,108,109,110; no window is emitted mixing frame-1 and frame-2 pixels.
- Reset pulse after pixel 9 of a frame, then a full frame → no win_valid before 11 new pixels are accepted; outputs read 0 during reset; subsequent windows match the first scenario exactly.
- Default 28x28 with random W-bit data, including all-ones pixels 0xFFFF → 676 windows; frame_done exactly once, at (25,25); all values bit-exact against a reference model.
- Row boundary check, IMG_W=IMG_H=4 → no win_valid after pixels at c=0 or c=1 of rows 2 and 3; win_valid after c=2 and c=3 only.
